masked_sbox_feeder: RTL



---
 rtl/masked_sbox_feeder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/masked_sbox_feeder.sv
// masked_sbox_feeder: nibble-serial two-share driver/collector around a one-stage masked PRINCE S-box.
// Latency: start accepted at edge 0, done pulses in cycle NIBBLES+2; busy high for NIBBLES+1 cycles.
// Backpressure: none; start is honoured only in IDLE. Macro FEEDER_LFSR_EN swaps r_in for a seeded 64-bit LFSR.
module masked_sbox_feeder #(
    parameter int NIBBLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   inv,
    input  logic [4*NIBBLES-1:0]   state_x_in,
    input  logic [4*NIBBLES-1:0]   state_y_in,
`ifdef FEEDER_LFSR_EN
    input  logic [63:0]            seed,
    input  logic                   seed_ld,
`else
    input  logic [15:0]            r_in,
`endif
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   state_x_out,
    output logic [4*NIBBLES-1:0]   state_y_out,
    output logic                   sb_en,
    output logic                   sb_sel,
    output logic [3:0]             sb_x,
    output logic [3:0]             sb_y,
    output logic [15:0]            sb_r,
    input  logic [3:0]             sb_zx,
    input  logic [3:0]             sb_zy
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          st;
    logic [CW-1:0]   cnt;
    // Share x and share y live in physically separate registers throughout.
    logic [W-1:0]    sh_x;
    logic [W-1:0]    sh_y;
    logic [W-1:0]    res_x;
    logic [W-1:0]    res_y;

    // Nibble k of each share leaves the shift registers with no logic in the path.
    assign sb_x = sh_x[3:0];
    assign sb_y = sh_y[3:0];

    // Sequencer: latch operands on start, stream nibbles out, collect S-box results one cycle later.
    // sb_sel is the latched (inverted) inv bit, held for the whole operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= S_IDLE;
            cnt         <= '0;
            sh_x        <= '0;
            sh_y        <= '0;
            res_x       <= '0;
            res_y       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sb_en       <= 1'b0;
            sb_sel      <= 1'b0;
            state_x_out <= '0;
            state_y_out <= '0;
        end else begin
            done <= 1'b0;
            case (st)
                S_IDLE: begin
                    if (start) begin
                        sh_x   <= state_x_in;
                        sh_y   <= state_y_in;
                        sb_sel <= ~inv;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        sb_en  <= 1'b1;
                        st     <= S_FEED;
                    end
                end
                S_FEED: begin
                    sh_x <= {4'h0, sh_x[W-1:4]};
                    sh_y <= {4'h0, sh_y[W-1:4]};
                    // The S-box output is valid from the second FEED cycle onward.
                    if (cnt != '0) begin
                        res_x <= {sb_zx, res_x[W-1:4]};
                        res_y <= {sb_zy, res_y[W-1:4]};
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(NIBBLES - 1)) begin
                        sb_en <= 1'b0;
                        st    <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Last nibble arrives now; publish the completed shares directly.
                    res_x       <= {sb_zx, res_x[W-1:4]};
                    res_y       <= {sb_zy, res_y[W-1:4]};
                    state_x_out <= {sb_zx, res_x[W-1:4]};
                    state_y_out <= {sb_zy, res_y[W-1:4]};
                    busy        <= 1'b0;
                    sb_sel      <= 1'b0;
                    done        <= 1'b1;
                    st          <= S_DONE;
                end
                default: begin
                    st <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FEEDER_LFSR_EN
    // Fibonacci LFSR x^64+x^63+x^61+x^60+1, shifting left; 16 fresh bits per step group.
    function automatic logic [63:0] lfsr_adv16(input logic [63:0] s);
        logic [63:0] v;
        v = s;
        for (int i = 0; i < 16; i++) begin
            v = {v[62:0], v[63] ^ v[62] ^ v[60] ^ v[59]};
        end
        return v;
    endfunction

    logic [63:0] lfsr_q;
    logic [63:0] lfsr_nxt;

    assign lfsr_nxt = lfsr_adv16(lfsr_q);
    // The low 16 bits after each advance are all newly generated, so no bit is reused.
    assign sb_r     = sb_en ? lfsr_nxt[15:0] : 16'h0000;

    // Seed in IDLE (all-zero seed would lock up), advance only while feeding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= 64'h0000_0000_0000_0001;
        end else if (st == S_IDLE && seed_ld) begin
            lfsr_q <= (seed == 64'h0) ? 64'h0000_0000_0000_0001 : seed;
        end else if (st == S_FEED) begin
            lfsr_q <= lfsr_nxt;
        end
    end
`else
    // External randomness passes through only while the S-box is enabled.
    assign sb_r = sb_en ? r_in : 16'h0000;
`endif

endmodule
